mdu_arbiter: RTL and testbench

- Sequencer and arbiter that shares one multiplier/divider pair between the alpha and beta issue slots.
- Accepts MULT/MULTU/DIV/DIVU requests and launches exactly one unit operation at a time.
- Tracks unit completion and issues a single one-cycle HI/LO commit to the owning slot.
- Stalls requesters while their operation is outstanding and discards in-flight results on flush. Sits in EX, between the issue slots and the multiplier/divider.

---
 rtl/mdu_arbiter.sv | 155 +++++++++++++++
 tb/tb_mdu_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_arbiter.sv
// Shares one multiplier/divider pair between the alpha and beta issue slots:
// grants one MULT/DIV at a time, waits for the unit and issues a one-cycle HI/LO commit.
module mdu_arbiter #(
  parameter int MAX_CYCLES = 64,
  parameter int CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        a_req,
  input  logic [1:0]  a_kind,
  input  logic [31:0] a_src_a,
  input  logic [31:0] a_src_b,
  input  logic        b_req,
  input  logic [1:0]  b_kind,
  input  logic [31:0] b_src_a,
  input  logic [31:0] b_src_b,
  output logic        a_stall,
  output logic        b_stall,
  output logic [1:0]  mult_op,
  output logic [1:0]  div_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        mult_done,
  input  logic        div_done,
  input  logic [63:0] mult_res,
  input  logic [63:0] div_res,
  output logic        hilo_wen,
  output logic [63:0] hilo_result,
  output logic        commit_beta,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_BUSY   = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

  state_e           state_q, state_d;
  logic [1:0]       kind_q, kind_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             owner_q, owner_d;
  logic             kill_q, kill_d;
  logic             seen_low_q, seen_low_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      result_q, result_d;

  logic        sel_done;
  logic [63:0] sel_res;
  logic        commit_a;
  logic        commit_b;

  // kind[1] selects the divider, kind[0] selects the unsigned flavour
  assign sel_done = kind_q[1] ? div_done : mult_done;
  assign sel_res  = kind_q[1] ? div_res  : mult_res;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    seen_low_d  = seen_low_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    mult_op     = 2'b00;
    div_op      = 2'b00;
    hilo_wen    = 1'b0;
    commit_beta = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush_i && (a_req || b_req)) begin
          owner_d    = !a_req;
          kind_d     = a_req ? a_kind  : b_kind;
          opa_d      = a_req ? a_src_a : b_src_a;
          opb_d      = a_req ? a_src_b : b_src_b;
          kill_d     = 1'b0;
          seen_low_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (kind_q[1]) div_op  = kind_q[0] ? 2'b01 : 2'b10;
        else           mult_op = kind_q[0] ? 2'b01 : 2'b10;
        if (flush_i) kill_d = 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_i)   kill_d     = 1'b1;
        if (!sel_done) seen_low_d = 1'b1;
        // done is high while the unit idles, so only a low-then-high edge means our result
        if (sel_done && seen_low_q) begin
          result_d = sel_res;
          state_d  = (kill_q || flush_i) ? S_IDLE : S_COMMIT;
        end else if (cnt_q == CNT_MAX) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        hilo_wen    = !kill_q && !flush_i;
        commit_beta = owner_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kind_q     <= 2'b00;
      opa_q      <= '0;
      opb_q      <= '0;
      owner_q    <= 1'b0;
      kill_q     <= 1'b0;
      seen_low_q <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      owner_q    <= owner_d;
      kill_q     <= kill_d;
      seen_low_q <= seen_low_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  // Handshake: a slot holds req and operands while its stall is high; stall low
  // with req high (and no flush) is the commit cycle that retires its operation.
  assign commit_a = (state_q == S_COMMIT) && !owner_q;
  assign commit_b = (state_q == S_COMMIT) &&  owner_q;
  assign a_stall  = a_req && !flush_i && !commit_a;
  assign b_stall  = b_req && !flush_i && !commit_b;

  assign busy        = (state_q != S_IDLE);
  assign unit_a      = opa_q;
  assign unit_b      = opb_q;
  assign hilo_result = result_q;

endmodule

// File: tb/tb_mdu_arbiter.sv
// Bench for mdu_arbiter: directed scenarios plus a randomized two-slot phase,
// with behavioural multiplier/divider models and per-slot expected queues.
module tb_mdu_arbiter;

  localparam int MAX_CYC = 64;
  localparam int N_RAND  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        a_req, b_req;
  logic [1:0]  a_kind, b_kind;
  logic [31:0] a_src_a, a_src_b, b_src_a, b_src_b;
  logic        a_stall, b_stall;
  logic [1:0]  mult_op, div_op;
  logic [31:0] unit_a, unit_b;
  logic        mult_done, div_done;
  logic [63:0] mult_res, div_res;
  logic        hilo_wen;
  logic [63:0] hilo_result;
  logic        commit_beta, busy, timeout;

  mdu_arbiter dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .a_req(a_req), .a_kind(a_kind), .a_src_a(a_src_a), .a_src_b(a_src_b),
    .b_req(b_req), .b_kind(b_kind), .b_src_a(b_src_a), .b_src_b(b_src_b),
    .a_stall(a_stall), .b_stall(b_stall),
    .mult_op(mult_op), .div_op(div_op), .unit_a(unit_a), .unit_b(unit_b),
    .mult_done(mult_done), .div_done(div_done), .mult_res(mult_res), .div_res(div_res),
    .hilo_wen(hilo_wen), .hilo_result(hilo_result), .commit_beta(commit_beta),
    .busy(busy), .timeout(timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];

  // observations of the current cycle, taken at the falling edge
  logic        obs_a_stall, obs_b_stall, obs_hilo_wen, obs_commit_beta, obs_busy, obs_timeout;
  logic [1:0]  obs_mult_op, obs_div_op;
  logic [31:0] obs_unit_a, obs_unit_b;
  logic [63:0] obs_hilo_result;

  // unit models: latency 0 means the unit never finishes, negative means random 2..6
  int          mult_lat = -1;
  int          div_lat  = -1;
  int          m_left = 0, d_left = 0;
  logic [63:0] m_fin, d_fin;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] k, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              qi, ri;
    logic [31:0]     q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (k)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      2'b10: begin
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        q = qi;
        r = ri;
        return {r, q};
      end
      default: begin
        q = x / y;
        r = x % y;
        return {r, q};
      end
    endcase
  endfunction

  function automatic int pick_left(input int cfg);
    int lat;
    lat = (cfg < 0) ? int'($urandom_range(2, 6)) : cfg;
    return (lat == 0) ? 0 : lat - 1;
  endfunction

  task automatic unit_reset();
    mult_done = 1'b1;
    div_done  = 1'b1;
    m_left    = 0;
    d_left    = 0;
  endtask

  task automatic unit_step();
    if (obs_mult_op != 2'b00) begin
      m_fin     = ref_result({1'b0, obs_mult_op == 2'b01}, obs_unit_a, obs_unit_b);
      m_left    = pick_left(mult_lat);
      mult_done = 1'b0;
      mult_res  = {$urandom, $urandom};
    end else if (!mult_done && m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        mult_done = 1'b1;
        mult_res  = m_fin;
      end
    end
    if (obs_div_op != 2'b00) begin
      d_fin    = ref_result({1'b1, obs_div_op == 2'b01}, obs_unit_a, obs_unit_b);
      d_left   = pick_left(div_lat);
      div_done = 1'b0;
      div_res  = {$urandom, $urandom};
    end else if (!div_done && d_left > 0) begin
      d_left--;
      if (d_left == 0) begin
        div_done = 1'b1;
        div_res  = d_fin;
      end
    end
  endtask

  // One clock: observe and score at the falling edge, then advance the unit models.
  task automatic cycle();
    @(negedge clk);
    obs_a_stall     = a_stall;
    obs_b_stall     = b_stall;
    obs_mult_op     = mult_op;
    obs_div_op      = div_op;
    obs_unit_a      = unit_a;
    obs_unit_b      = unit_b;
    obs_hilo_wen    = hilo_wen;
    obs_hilo_result = hilo_result;
    obs_commit_beta = commit_beta;
    obs_busy        = busy;
    obs_timeout     = timeout;
    chk("one_op_field", (obs_mult_op != 2'b00) && (obs_div_op != 2'b00), 1'b0);
    if (obs_hilo_wen === 1'b1) begin
      if (obs_commit_beta) begin
        chk("wen_expected_b", exp_b_q.size() != 0, 1'b1);
        if (exp_b_q.size() != 0) chk("result_b", obs_hilo_result, exp_b_q.pop_front());
      end else begin
        chk("wen_expected_a", exp_a_q.size() != 0, 1'b1);
        if (exp_a_q.size() != 0) chk("result_a", obs_hilo_result, exp_a_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (rst) unit_reset();
    else unit_step();
  endtask

  // driver tasks
  task automatic drive_a(input logic [1:0] k, input logic [31:0] x, input logic [31:0] y);
    a_req = 1'b1; a_kind = k; a_src_a = x; a_src_b = y;
  endtask

  task automatic drive_b(input logic [1:0] k, input logic [31:0] x, input logic [31:0] y);
    b_req = 1'b1; b_kind = k; b_src_a = x; b_src_b = y;
  endtask

  task automatic wait_release(input bit beta, input int bound);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (((beta ? obs_b_stall : obs_a_stall) === 1'b1) && n < bound);
    chk(beta ? "release_b" : "release_a", beta ? obs_b_stall : obs_a_stall, 1'b0);
    chk("release_wen", obs_hilo_wen, 1'b1);
    chk("release_owner", obs_commit_beta, beta);
    if (beta) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  task automatic new_op(input bit beta);
    logic [1:0]  k;
    logic [31:0] x, y;
    k = 2'($urandom_range(0, 3));
    x = $urandom;
    y = $urandom;
    if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 20));
    if (k[1] && $urandom_range(0, 1) == 1) y = 32'($urandom_range(1, 15));
    if (k[1] && (y == 32'd0 || (k == 2'b10 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      y = 32'd3;
    if (beta) begin
      exp_b_q.push_back(ref_result(k, x, y));
      drive_b(k, x, y);
    end else begin
      exp_a_q.push_back(ref_result(k, x, y));
      drive_a(k, x, y);
    end
  endtask

  initial begin
    int  n;
    int  n_issued, n_done;
    bit  a_pend, b_pend;
    rst = 1'b1; flush_i = 1'b0;
    a_req = 1'b0; a_kind = 2'b00; a_src_a = '0; a_src_b = '0;
    b_req = 1'b0; b_kind = 2'b00; b_src_a = '0; b_src_b = '0;
    mult_res = '0; div_res = '0;
    unit_reset();

    // reset state
    cycle();
    chk("rst_busy", obs_busy, 1'b0);
    chk("rst_wen", obs_hilo_wen, 1'b0);
    chk("rst_mult_op", obs_mult_op, 2'b00);
    chk("rst_div_op", obs_div_op, 2'b00);
    chk("rst_result", obs_hilo_result, 64'd0);
    chk("rst_unit_a", obs_unit_a, 32'd0);
    chk("rst_timeout", obs_timeout, 1'b0);
    chk("rst_stalls", {obs_a_stall, obs_b_stall, obs_commit_beta}, 3'b000);
    rst = 1'b0;

    // reset in the middle of BUSY with done held low
    mult_lat = 0;
    drive_a(2'b00, 32'd5, 32'd6);
    cycle();
    cycle();
    chk("t1_issue", obs_mult_op, 2'b10);
    cycle();
    cycle();
    chk("t1_busy", obs_busy, 1'b1);
    rst = 1'b1;
    cycle();
    chk("t1_rst_busy", obs_busy, 1'b0);
    chk("t1_rst_wen", obs_hilo_wen, 1'b0);
    chk("t1_rst_op", obs_mult_op, 2'b00);
    a_req = 1'b0;
    rst = 1'b0;
    mult_lat = -1;
    cycle();
    chk("t1_idle", obs_busy, 1'b0);

    // MULT -1 * 2, multiplier finishes 3 cycles after the op
    mult_lat = 3;
    drive_a(2'b00, 32'hFFFF_FFFF, 32'd2);
    exp_a_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    cycle();
    chk("t2_grant_stall", obs_a_stall, 1'b1);
    chk("t2_grant_op", obs_mult_op, 2'b00);
    cycle();
    chk("t2_issue_op", obs_mult_op, 2'b10);
    chk("t2_unit_a", obs_unit_a, 32'hFFFF_FFFF);
    chk("t2_unit_b", obs_unit_b, 32'd2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_wait_op", obs_mult_op, 2'b00);
      chk("t2_wait_wen", obs_hilo_wen, 1'b0);
      chk("t2_wait_stall", obs_a_stall, 1'b1);
    end
    cycle();
    chk("t2_wen", obs_hilo_wen, 1'b1);
    chk("t2_result", obs_hilo_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2_owner", obs_commit_beta, 1'b0);
    chk("t2_stall_drop", obs_a_stall, 1'b0);
    a_req = 1'b0;
    cycle();
    chk("t2_after_wen", obs_hilo_wen, 1'b0);
    chk("t2_after_busy", obs_busy, 1'b0);

    // simultaneous DIVU (alpha) and MULTU (beta): alpha first
    div_lat = 4;
    mult_lat = 2;
    drive_a(2'b11, 32'd7, 32'd2);
    drive_b(2'b01, 32'd7, 32'd2);
    exp_a_q.push_back({32'd1, 32'd3});
    exp_b_q.push_back(64'd14);
    n = 0;
    do begin
      cycle();
      chk("t3_b_held", obs_b_stall, 1'b1);
      n++;
    end while (obs_a_stall === 1'b1 && n < 20);
    chk("t3_a_latency", n, 7);
    chk("t3_a_wen", obs_hilo_wen, 1'b1);
    chk("t3_a_owner", obs_commit_beta, 1'b0);
    chk("t3_a_result", obs_hilo_result, {32'd1, 32'd3});
    a_req = 1'b0;
    cycle();
    chk("t3_b_grant_idle", obs_busy, 1'b0);
    cycle();
    chk("t3_b_issue", obs_mult_op, 2'b01);
    chk("t3_b_unit_a", obs_unit_a, 32'd7);
    wait_release(1'b1, 20);
    chk("t3_b_result", obs_hilo_result, 64'd14);

    // flush two cycles after ISSUE: unit runs to done, nothing written
    mult_lat = 5;
    drive_a(2'b01, 32'd3, 32'd4);
    cycle();
    cycle();
    chk("t4_issue", obs_mult_op, 2'b01);
    cycle();
    flush_i = 1'b1;
    a_req = 1'b0;
    cycle();
    chk("t4_flush_busy", obs_busy, 1'b1);
    chk("t4_flush_stall", obs_a_stall, 1'b0);
    flush_i = 1'b0;
    n = 0;
    do begin
      cycle();
      if (obs_busy === 1'b1) n++;
    end while (obs_busy === 1'b1 && n < 20);
    chk("t4_busy_until_done", n, 3);
    chk("t4_no_wen", obs_hilo_wen, 1'b0);
    mult_lat = 2;
    drive_b(2'b00, 32'd2, 32'd3);
    exp_b_q.push_back(64'd6);
    wait_release(1'b1, 20);

    // divider never finishes: watchdog
    div_lat = 0;
    drive_a(2'b10, 32'd100, 32'd7);
    cycle();
    cycle();
    chk("t5_issue", obs_div_op, 2'b10);
    n = 0;
    do begin
      cycle();
      if (obs_timeout !== 1'b1) n++;
    end while (obs_timeout !== 1'b1 && n < 200);
    chk("t5_timeout", obs_timeout, 1'b1);
    chk("t5_busy_cycles", n, MAX_CYC);
    chk("t5_no_wen", obs_hilo_wen, 1'b0);
    a_req = 1'b0;
    unit_reset();
    div_lat = -1;
    cycle();
    chk("t5_idle", obs_busy, 1'b0);
    chk("t5_single_pulse", obs_timeout, 1'b0);

    // flush in the COMMIT cycle
    mult_lat = 2;
    drive_a(2'b00, 32'd3, 32'd5);
    drive_b(2'b01, 32'd1, 32'd1);
    for (int i = 0; i < 4; i++) cycle();
    chk("t6_pre_stalls", {obs_a_stall, obs_b_stall}, 2'b11);
    flush_i = 1'b1;
    cycle();
    chk("t6_busy", obs_busy, 1'b1);
    chk("t6_wen", obs_hilo_wen, 1'b0);
    chk("t6_stalls", {obs_a_stall, obs_b_stall}, 2'b00);
    flush_i = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    cycle();
    chk("t6_idle", obs_busy, 1'b0);

    // randomized traffic from both slots
    mult_lat = -1;
    div_lat = -1;
    a_pend = 1'b0;
    b_pend = 1'b0;
    n_issued = 0;
    n_done = 0;
    for (int t = 0; t < 3000 && n_done < N_RAND; t++) begin
      if (!a_pend && n_issued < N_RAND && $urandom_range(0, 2) == 0) begin
        new_op(1'b0);
        a_pend = 1'b1;
        n_issued++;
      end
      if (!b_pend && n_issued < N_RAND && $urandom_range(0, 2) == 0) begin
        new_op(1'b1);
        b_pend = 1'b1;
        n_issued++;
      end
      cycle();
      if (a_pend && obs_a_stall === 1'b0) begin
        chk("rand_a_wen", {obs_hilo_wen, obs_commit_beta}, 2'b10);
        a_req = 1'b0;
        a_pend = 1'b0;
        n_done++;
      end
      if (b_pend && obs_b_stall === 1'b0) begin
        chk("rand_b_wen", {obs_hilo_wen, obs_commit_beta}, 2'b11);
        b_req = 1'b0;
        b_pend = 1'b0;
        n_done++;
      end
    end
    chk("rand_all_done", n_done, N_RAND);
    cycle();
    chk("final_idle", obs_busy, 1'b0);
    chk("exp_a_drained", exp_a_q.size(), 0);
    chk("exp_b_drained", exp_b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
